// File: rtl/mte_receiver.sv
// rtl/mte_receiver.sv - MAC-then-Encrypt receive sequencer: deframe, decrypt, re-MAC, check, present
//
// Ports:
//   clock, reset_n              rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_byte   byte-serial ciphertext frame {Enc(data), Enc(MAC)}, MSB byte first
//   dec_req/dec_in/dec_done/dec_out   external decryption engine handshake
//   mac_req/mac_in/mac_done/mac_out   external MAC generation engine handshake
//   out_valid/out_ready         result handshake
//   out_data/out_len            plaintext (0 when rejected) and bytes before the first 0x03
//   valid_key, timeout          MAC match flag, engine watchdog expiry flag
module mte_receiver #(
    parameter int N       = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    output logic                  dec_req,
    output logic [N-1:0]          dec_in,
    input  logic                  dec_done,
    input  logic [N-1:0]          dec_out,
    output logic                  mac_req,
    output logic [N-1:0]          mac_in,
    input  logic                  mac_done,
    input  logic [N-1:0]          mac_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_data,
    output logic [$clog2(N/8):0]  out_len,
    output logic                  valid_key,
    output logic                  timeout
);
    localparam int NB = N / 8;
    localparam int FB = 2 * NB;
    localparam int CW = $clog2(FB);
    localparam int LW = $clog2(NB) + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_RECV,
        S_DEC_D,
        S_DEC_M,
        S_GEN,
        S_CHECK,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            first_q;   // current cycle is the first one of a wait state
    logic [WW-1:0]   wd_q;
    logic [CW-1:0]   cnt_q;

    // Datapath registers: deliberately not reset, always overwritten before use.
    logic [2*N-1:0]  frame_q;
    logic [N-1:0]    plain_q;
    logic [N-1:0]    rx_mac_q;
    logic [N-1:0]    calc_mac_q;

    logic            accept;
    logic            wait_st;
    logic            done_ok;
    logic            expire;
    logic [LW-1:0]   scan_len;

    assign accept  = (state == S_RECV) && in_valid && in_ready;
    assign wait_st = (state == S_DEC_D) || (state == S_DEC_M) || (state == S_GEN);
    // done is only honoured after the request cycle; a done on the same cycle
    // as watchdog expiry still wins.
    assign done_ok = wait_st && !first_q && ((state == S_GEN) ? mac_done : dec_done);
    assign expire  = wait_st && !done_ok && (wd_q == WW'(TIMEOUT - 1));

    // Index of the first 0x03 byte counted from the MSB; NB when absent.
    always_comb begin
        scan_len = LW'(NB);
        for (int i = NB - 1; i >= 0; i--) begin
            if (plain_q[N-1-8*i -: 8] == 8'h03) begin
                scan_len = LW'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        dec_req  = 1'b0;
        mac_req  = 1'b0;
        dec_in   = frame_q[2*N-1:N];
        mac_in   = plain_q;
        case (state)
            S_RECV: begin
                if (accept && (cnt_q == CW'(FB - 1))) begin
                    state_nx = S_DEC_D;
                end
            end
            S_DEC_D: begin
                dec_req = first_q;
                if (done_ok) begin
                    state_nx = S_DEC_M;
                end else if (expire) begin
                    state_nx = S_OUT;
                end
            end
            S_DEC_M: begin
                dec_req = first_q;
                dec_in  = frame_q[N-1:0];
                if (done_ok) begin
                    state_nx = S_GEN;
                end else if (expire) begin
                    state_nx = S_OUT;
                end
            end
            S_GEN: begin
                mac_req = first_q;
                if (done_ok) begin
                    state_nx = S_CHECK;
                end else if (expire) begin
                    state_nx = S_OUT;
                end
            end
            S_CHECK: begin
                state_nx = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_nx = S_RECV;
                end
            end
            default: begin
                state_nx = S_RECV;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RECV;
            first_q   <= 1'b0;
            wd_q      <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
            valid_key <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state   <= state_nx;
            first_q <= (state_nx != state) &&
                       ((state_nx == S_DEC_D) || (state_nx == S_DEC_M) || (state_nx == S_GEN));
            if (state_nx != state) begin
                wd_q <= '0;
            end else if (wait_st) begin
                wd_q <= wd_q + 1'b1;
            end
            if (state_nx != S_RECV) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            in_ready  <= (state_nx == S_RECV);
            out_valid <= (state_nx == S_OUT);
            if (state == S_CHECK) begin
                valid_key <= (rx_mac_q == calc_mac_q);
                timeout   <= 1'b0;
                out_data  <= (rx_mac_q == calc_mac_q) ? plain_q : '0;
                out_len   <= (rx_mac_q == calc_mac_q) ? scan_len : '0;
            end else if (expire) begin
                valid_key <= 1'b0;
                timeout   <= 1'b1;
                out_data  <= '0;
                out_len   <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            frame_q <= {frame_q[2*N-9:0], in_byte};
        end
        if (done_ok && (state == S_DEC_D)) begin
            plain_q <= dec_out;
        end
        if (done_ok && (state == S_DEC_M)) begin
            rx_mac_q <= dec_out;
        end
        if (done_ok && (state == S_GEN)) begin
            calc_mac_q <= mac_out;
        end
    end
endmodule

// File: tb/tb_mte_receiver.sv
// tb/tb_mte_receiver.sv - self-checking bench for mte_receiver with engine models and frame model
module tb_mte_receiver;
    localparam int N    = 256;
    localparam int TO   = 1024;
    localparam int NB   = N / 8;
    localparam int MAXF = 64;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [7:0]           in_byte = 8'h00;
    logic                 dec_req;
    logic [N-1:0]         dec_in;
    logic                 dec_done;
    logic [N-1:0]         dec_out;
    logic                 mac_req;
    logic [N-1:0]         mac_in;
    logic                 mac_done;
    logic [N-1:0]         mac_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0]         out_data;
    logic [$clog2(NB):0]  out_len;
    logic                 valid_key;
    logic                 timeout;

    mte_receiver #(.N(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .dec_req(dec_req), .dec_in(dec_in), .dec_done(dec_done), .dec_out(dec_out),
        .mac_req(mac_req), .mac_in(mac_in), .mac_done(mac_done), .mac_out(mac_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_len(out_len), .valid_key(valid_key), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int n_sent = 0;
    int n_done = 0;
    int rdy_mode = 2;  // 0 random, 1 held low, 2 held high

    logic [2*N-1:0] ct_arr [MAXF];
    int             dly1 [MAXF], dly2 [MAXF], dly3 [MAXF];
    int             t_last [MAXF];
    logic [N-1:0]   exp_data [MAXF];
    int             exp_len [MAXF], exp_lat [MAXF];
    bit             exp_key [MAXF], exp_tmo [MAXF];
    bit             lit_en [MAXF];
    logic [N-1:0]   lit_data [MAXF];
    int             lit_len [MAXF], lit_lat [MAXF];
    bit             lit_key [MAXF], lit_tmo [MAXF];

    always @(posedge clock) begin
        #1;
        out_ready = (rdy_mode == 2) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Decryption engine: XOR with 0x5A per byte.
    initial begin : dec_eng
        int f, d;
        logic [N-1:0] v;
        dec_done = 1'b0;
        dec_out  = '0;
        forever begin
            @(negedge clock);
            if (reset_n && dec_req) begin
                f = n_sent - 1;
                d = (dec_in == ct_arr[f][2*N-1:N]) ? dly1[f] : dly2[f];
                v = dec_in ^ {NB{8'h5A}};
                repeat (d) @(posedge clock);
                #1 dec_done = 1'b1;
                dec_out = v;
                @(posedge clock);
                #1 dec_done = 1'b0;
            end
        end
    end

    // MAC engine: bitwise NOT.
    initial begin : mac_eng
        int d;
        logic [N-1:0] v;
        mac_done = 1'b0;
        mac_out  = '0;
        forever begin
            @(negedge clock);
            if (reset_n && mac_req) begin
                d = dly3[n_sent - 1];
                v = ~mac_in;
                repeat (d) @(posedge clock);
                #1 mac_done = 1'b1;
                mac_out = v;
                @(posedge clock);
                #1 mac_done = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single compare process: reset values, in_ready gating, and every out_valid cycle.
    initial begin : compare
        int  k, rst_age;
        bit  first_seen, hs_prev;
        first_seen = 0;
        hs_prev = 0;
        rst_age = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                rst_age = 0;
                first_seen = 0;
                hs_prev = 0;
                chk("rst_in_ready", in_ready, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_reqs", {dec_req, mac_req}, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_flags", {out_len, valid_key, timeout}, 0);
            end else begin
                rst_age++;
                if (rst_age == 2) chk("in_ready_after_reset", in_ready, 1);
                if (hs_prev) begin
                    chk("in_ready_after_handshake", in_ready, 1);
                    hs_prev = 0;
                end
                if (n_sent != n_done) chk("in_ready_busy", in_ready, 0);
                if (out_valid) begin
                    if (n_done == n_sent) begin
                        chk("spurious_out_valid", out_valid, 0);
                    end else begin
                        k = n_done;
                        if (!first_seen) begin
                            chk("latency", cyc + 1 - t_last[k], exp_lat[k]);
                            if (lit_en[k]) chk("lit_latency", cyc + 1 - t_last[k], lit_lat[k]);
                            first_seen = 1;
                        end
                        chk("out_data", out_data, exp_data[k]);
                        chk("out_len", out_len, exp_len[k]);
                        chk("valid_key", valid_key, exp_key[k]);
                        chk("timeout", timeout, exp_tmo[k]);
                        if (lit_en[k]) begin
                            chk("lit_out_data", out_data, lit_data[k]);
                            chk("lit_out_len", out_len, lit_len[k]);
                            chk("lit_flags", {valid_key, timeout}, {lit_key[k], lit_tmo[k]});
                        end
                        if (out_ready) begin
                            n_done++;
                            first_seen = 0;
                            hs_prev = 1;
                        end
                    end
                end
            end
        end
    end

    // Builds the ciphertext frame and derives the expected result from the link rules.
    task automatic prep(input logic [N-1:0] p, input int flip_idx, input logic [7:0] flip_mask,
                        input int d1, input int d2, input int d3);
        logic [2*N-1:0] ct;
        logic [N-1:0]   od;
        logic [7:0]     pd [NB];
        logic [7:0]     rm [NB];
        bit             match;
        int             len, k;
        k = n_sent;
        for (int i = 0; i < NB; i++) begin
            ct[2*N-1-8*i -: 8] = p[N-1-8*i -: 8] ^ 8'h5A;
            ct[N-1-8*i -: 8]   = ~p[N-1-8*i -: 8] ^ 8'h5A;
        end
        if (flip_idx >= 0) ct[2*N-1-8*flip_idx -: 8] = ct[2*N-1-8*flip_idx -: 8] ^ flip_mask;
        for (int i = 0; i < NB; i++) begin
            pd[i] = ct[2*N-1-8*i -: 8] ^ 8'h5A;
            rm[i] = ct[N-1-8*i -: 8] ^ 8'h5A;
            od[N-1-8*i -: 8] = pd[i];
        end
        match = 1;
        for (int i = 0; i < NB; i++) if (rm[i] != (pd[i] ^ 8'hFF)) match = 0;
        len = NB;
        for (int i = 0; i < NB; i++) begin
            if (pd[i] == 8'h03) begin
                len = i;
                break;
            end
        end
        ct_arr[k] = ct;
        dly1[k] = d1;
        dly2[k] = d2;
        dly3[k] = d3;
        lit_en[k] = 0;
        exp_tmo[k] = (d1 >= TO) || (d2 >= TO) || (d3 >= TO);
        if (d1 >= TO)      exp_lat[k] = 1 + TO;
        else if (d2 >= TO) exp_lat[k] = 2 + d1 + TO;
        else if (d3 >= TO) exp_lat[k] = 3 + d1 + d2 + TO;
        else               exp_lat[k] = 5 + d1 + d2 + d3;
        exp_key[k]  = exp_tmo[k] ? 1'b0 : match;
        exp_data[k] = exp_key[k] ? od : '0;
        exp_len[k]  = exp_key[k] ? len : 0;
    endtask

    task automatic set_lit(input logic [N-1:0] d, input int len, input bit key, input bit tmo,
                           input int lat);
        lit_en[n_sent]   = 1;
        lit_data[n_sent] = d;
        lit_len[n_sent]  = len;
        lit_key[n_sent]  = key;
        lit_tmo[n_sent]  = tmo;
        lit_lat[n_sent]  = lat;
    endtask

    task automatic send(input int nbytes, input bit gaps);
        int w;
        for (int i = 0; i < nbytes; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            in_byte  = ct_arr[n_sent][2*N-1-8*i -: 8];
            in_valid = 1'b1;
            w = 0;
            @(negedge clock);
            while (!in_ready) begin
                w++;
                if (w > 4000) begin
                    $display("FAIL in_ready_wait: byte %0d never accepted", i);
                    $fatal(1, "stalled");
                end
                @(negedge clock);
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (nbytes == 2 * NB) begin
            t_last[n_sent] = cyc;
            n_sent++;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (n_done != n_sent) begin
            @(negedge clock);
            w++;
            if (w > 6000) begin
                $display("FAIL result_wait: frame %0d produced no result", n_done);
                $fatal(1, "stalled");
            end
        end
    endtask

    initial begin : main
        logic [N-1:0] pa, pb, pr;
        int d [3];
        int flip, w;
        logic [N-1:0] lit_a, lit_b;
        lit_a = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        lit_b = 256'h101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f;
        for (int i = 0; i < NB; i++) begin
            pa[N-1-8*i -: 8] = 8'(i);
            pb[N-1-8*i -: 8] = 8'(8'h10 + i);
        end
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        prep(pa, -1, 8'h00, 1, 1, 1);
        set_lit(lit_a, 3, 1, 0, 8);
        send(2 * NB, 0);
        wait_idle();

        prep(pb, -1, 8'h00, 1, 1, 1);
        set_lit(lit_b, 32, 1, 0, 8);
        send(2 * NB, 0);
        wait_idle();

        prep(pa, 40, 8'hFF, 1, 1, 1);
        set_lit('0, 0, 0, 0, 8);
        send(2 * NB, 0);
        wait_idle();

        prep(pa, -1, 8'h00, TO + 3, 1, 1);
        set_lit('0, 0, 0, 1, TO + 1);
        send(2 * NB, 0);
        wait_idle();

        rdy_mode = 1;
        prep(pa, -1, 8'h00, 1, 1, 1);
        set_lit(lit_a, 3, 1, 0, 8);
        send(2 * NB, 0);
        w = 0;
        @(negedge clock);
        while (!out_valid) begin
            w++;
            if (w > 200) begin
                $display("FAIL out_valid_wait: no result for stalled frame");
                $fatal(1, "stalled");
            end
            @(negedge clock);
        end
        repeat (10) @(negedge clock);
        rdy_mode = 2;
        prep(pa, -1, 8'h00, 1, 1, 1);
        set_lit(lit_a, 3, 1, 0, 8);
        send(2 * NB, 0);
        wait_idle();

        prep(pb, -1, 8'h00, 1, 1, 1);
        send(20, 0);
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        prep(pa, -1, 8'h00, 1, 1, 1);
        set_lit(lit_a, 3, 1, 0, 8);
        send(2 * NB, 0);
        wait_idle();

        rdy_mode = 0;
        for (int f = 0; f < 25; f++) begin
            pr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) pr[N-1-8*$urandom_range(0, NB-1) -: 8] = 8'h03;
            flip = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2*NB-1)) : -1;
            for (int s = 0; s < 3; s++) d[s] = $urandom_range(1, 4);
            if ($urandom_range(0, 11) == 0) d[$urandom_range(0, 2)] = TO + 3;
            prep(pr, flip, 8'($urandom_range(1, 255)), d[0], d[1], d[2]);
            send(2 * NB, 1);
        end
        wait_idle();
        rdy_mode = 2;
        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mte_receiver.md
# mte_receiver

Receive side of the MAC-then-Encrypt link. It accepts a byte-serial ciphertext frame {Enc(data), Enc(MAC)} and sequences the external decryption and MAC-generation engines through request/done handshakes. It then compares the regenerated MAC with the decrypted MAC, finds the 0x03 end-of-file byte, and presents the plaintext, or all-zeros on MAC mismatch, through a valid/ready output port. It sits between the serial channel and the consumer, mirroring the transmit-side MTE datapath.

## Interface
- N, 256, data and MAC width in bits; multiple of 8
- TIMEOUT, 1024, maximum cycles to wait for any engine done
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_byte  in  8  ciphertext byte; first byte is frame bit 2N-1
- dec_req  out  1  one-cycle decryption request
- dec_in  out  N  ciphertext block to decrypt; held until dec_done
- dec_done  in  1  dec_out valid this cycle
- dec_out  in  N  decrypted block
- mac_req  out  1  one-cycle MAC request
- mac_in  out  N  plaintext to authenticate; held until mac_done
- mac_done  in  1  mac_out valid this cycle
- mac_out  in  N  generated MAC
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  N  plaintext, or 0 if rejected
- out_len  out  $clog2(N/8)+1  plaintext bytes before first 0x03
- valid_key  out  1  1 = MAC match
- timeout  out  1  1 = an engine exceeded TIMEOUT

## Operation
- Frame is 2N/8 bytes, MSB first. Bits [2N-1:N] are the data ciphertext; bits [N-1:0] are the MAC ciphertext.
- The byte counter runs from 0 to 2N/8-1, width $clog2(2N/8). It clears on reset and on leaving RECV.
- States and transitions:
  - RECV: in_ready=1. Each accepted byte is shifted in. The last byte moves the FSM to DEC_D.
  - DEC_D: pulse dec_req with dec_in = data ciphertext. On dec_done, capture plaintext and go to DEC_M.
  - DEC_M: pulse dec_req with dec_in = MAC ciphertext. On dec_done, capture the received MAC and go to GEN.
  - GEN: pulse mac_req with mac_in = plaintext. On mac_done, capture the computed MAC and go to CHECK.
  - CHECK (1 cycle): registers the results below and goes to OUT.
    - valid_key = (received MAC == computed MAC).
    - out_len = index of the first byte equal to 0x03, scanning from the MSB byte; N/8 if none.
    - On mismatch, out_data=0 and out_len=0.
  - OUT: out_valid=1 with outputs stable. When out_ready is high, the FSM returns to RECV.
- req pulses occur only in the first cycle of a state. done is sampled from the cycle after req onward. done in any other state is ignored.
- Watchdog: the counter resets on entering DEC_D, DEC_M or GEN and counts each waiting cycle. On reaching TIMEOUT with no done, the FSM goes to OUT with timeout=1, valid_key=0, out_data=0 and out_len=0.
- A late done arriving after a timeout is ignored.
- Ciphertext and intermediate registers are not cleared by reset. Their contents do not affect outputs until overwritten.

## Timing
- Reset values: state=RECV, in_ready=0, dec_req=0, mac_req=0, out_valid=0, out_data=0, out_len=0, valid_key=0, timeout=0. dec_in and mac_in are don't-care.
- in_ready is registered and rises the first edge after reset_n deasserts. It stays low from the last-byte acceptance until the OUT handshake completes.
- With the last byte accepted at edge T and each engine returning done one cycle after req:
  - dec_req at T+1 and T+3
  - mac_req at T+5
  - CHECK at T+7
  - out_valid at T+8
- General latency: 5 + d1 + d2 + d3 cycles, where d1, d2, d3 are the engine req-to-done delays.
- OUT handshake: out_valid && out_ready at edge E puts in_ready=1 at E+1. The next frame's first byte can be accepted at E+1.
- Reset mid-operation, including during OUT or an outstanding request, aborts immediately. The partial frame is discarded and no out_valid is produced.

## Test plan
- Bench setup for the tests below:
  - Engine models: dec = XOR with 0x5A repeated; mac = bitwise NOT; both return done 1 cycle after req.
  - Frame: plaintext bytes 0x00..0x1F, sent as (p^0x5A) followed by (~p^0x5A).
- Send this frame -> out_valid at T+8, valid_key=1, out_data=0x000102…1F, out_len=3.
- Plaintext 0x10..0x2F, same encoding -> valid_key=1, out_len=32; in_ready=0 throughout DEC_D through OUT.
- First frame with MAC byte 40 flipped -> valid_key=0, out_data=0, out_len=0, timeout=0.
- dec_done held low -> out_valid exactly TIMEOUT cycles after the DEC_D dec_req, with timeout=1; a late dec_done is ignored.
- out_ready held low 10 cycles -> outputs stable, in_ready=0; release -> next frame accepted one cycle later and decoded correctly.
- reset_n pulsed after 20 bytes, then a full 64-byte frame -> no spurious out_valid; the new frame decodes as in the first test.
